disp_arbiter: RTL and testbench

Round-robin arbiter that shares the single 4-digit hex display datapath (16-bit data bus into the hex display driver) between four requesters, e.g. the 16-bit counter, a debug register and two status sources. Each granted requester keeps the display for a minimum dwell of DWELL slow ticks so the value stays readable. The tick comes from one of the clock dividers. The block sits between the requesters and the hex display driver and drives the data bus plus a blanking mask.

---
 rtl/disp_arbiter.sv | 148 ++++++++++++++
 tb/tb_disp_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// Round-robin owner selection for the shared 4-digit hex display, with a minimum dwell in ticks.
// Optional DISP_ARB_PRIO0_EN: requester 0 preempts any other owner and wins from IDLE.
module disp_arbiter #(
    parameter int unsigned DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [3:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] data3,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic [15:0] dout,
    output logic [3:0]  blank
);

    // state | meaning
    // IDLE  | no owner, display blanked, dout forced to zero
    // HOLD  | one requester owns the display; cnt counts its dwell ticks
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_CNT = 8'(DWELL);

    state_t      st, st_nxt;
    logic [1:0]  owner_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  grant_nxt;
    logic [3:0]  others;
    logic [1:0]  pick_any, pick_oth, sel;
    logic        take;
    logic        prio_hold;
    logic        prio_idle;
    logic [15:0] owner_data;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        logic [1:0] res;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef DISP_ARB_PRIO0_EN
    assign prio_hold = (st == HOLD) && (owner != 2'd0) && req[0];
    assign prio_idle = req[0];
`else
    assign prio_hold = 1'b0;
    assign prio_idle = 1'b0;
`endif

    assign others   = req & ~grant;
    assign pick_any = rr_pick(req, ptr);
    assign pick_oth = rr_pick(others, ptr);

    always_comb begin
        st_nxt    = st;
        owner_nxt = owner;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        take      = 1'b0;
        sel       = pick_oth;
        case (st)
            IDLE: begin
                if (req != 4'd0) begin
                    take = 1'b1;
                    sel  = prio_idle ? 2'd0 : pick_any;
                end
            end
            HOLD: begin
                // Release beats preemption, expiry and tick; a switch swallows the tick.
                if (!req[owner]) begin
                    if (others != 4'd0) begin
                        take = 1'b1;
                    end else begin
                        st_nxt    = IDLE;
                        owner_nxt = 2'd0;
                        grant_nxt = 4'd0;
                        cnt_nxt   = 8'd0;
                    end
                end else if (prio_hold) begin
                    take = 1'b1;
                    sel  = 2'd0;
                end else if ((cnt == DWELL_CNT) && (others != 4'd0)) begin
                    take = 1'b1;
                end else if (tick && (cnt < DWELL_CNT)) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: st_nxt = IDLE;
        endcase
        if (take) begin
            st_nxt    = HOLD;
            owner_nxt = sel;
            grant_nxt = 4'b0001 << sel;
            cnt_nxt   = 8'd0;
            ptr_nxt   = sel + 2'd1;
        end
    end

    always_comb begin
        owner_data = data0;
        case (owner)
            2'd0: owner_data = data0;
            2'd1: owner_data = data1;
            2'd2: owner_data = data2;
            2'd3: owner_data = data3;
            default: owner_data = data0;
        endcase
    end

    // dout/blank follow the registered state and owner, one cycle behind the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st    <= IDLE;
            owner <= 2'd0;
            grant <= 4'd0;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
            dout  <= 16'h0000;
            blank <= 4'hF;
        end else begin
            st    <= st_nxt;
            owner <= owner_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            dout  <= (st == HOLD) ? owner_data : 16'h0000;
            blank <= (st == HOLD) ? 4'h0 : 4'hF;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed-vector bench for disp_arbiter; expectations are queued per cycle and checked by a monitor.
module tb_disp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [3:0]  req;
    logic [15:0] data0, data1, data2, data3;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [15:0] dout;
    logic [3:0]  blank;

    disp_arbiter #(.DWELL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .data3 (data3),
        .grant (grant),
        .owner (owner),
        .dout  (dout),
        .blank (blank)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [3:0]  g;
        logic [1:0]  o;
        logic [15:0] d;
        logic [3:0]  b;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

`ifdef DISP_ARB_PRIO0_EN
    localparam logic [3:0]  RR_REQ = 4'b0110;
    localparam logic [1:0]  RR_A   = 2'd1;
    localparam logic [1:0]  RR_B   = 2'd2;
    localparam logic [15:0] RR_DA  = 16'hABCD;
    localparam logic [15:0] RR_DB  = 16'h5A5A;
`else
    localparam logic [3:0]  RR_REQ = 4'b0011;
    localparam logic [1:0]  RR_A   = 2'd0;
    localparam logic [1:0]  RR_B   = 2'd1;
    localparam logic [15:0] RR_DA  = 16'h1234;
    localparam logic [15:0] RR_DB  = 16'hABCD;
`endif
    localparam logic [3:0] GA = 4'b0001 << RR_A;
    localparam logic [3:0] GB = 4'b0001 << RR_B;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic row(input logic r, input logic [3:0] rq, input logic tk,
                       input logic [3:0] g, input logic [1:0] o,
                       input logic [15:0] d, input logic [3:0] b, input string nm);
        exp_t e;
        rst_n  = r;
        req    = rq;
        tick   = tk;
        e.at   = cyc + 1;
        e.name = nm;
        e.g    = g;
        e.o    = o;
        e.d    = d;
        e.b    = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            tests = tests + 1;
            if (e.at < cyc) begin
                fails = fails + 1;
                $display("FAIL %s: check missed, due cycle %0d seen at %0d", e.name, e.at, cyc);
            end else if (grant !== e.g || owner !== e.o || dout !== e.d || blank !== e.b) begin
                fails = fails + 1;
                $display("FAIL %s @%0d: got grant=%b owner=%0d dout=%h blank=%h, want grant=%b owner=%0d dout=%h blank=%h",
                         e.name, cyc, grant, owner, dout, blank, e.g, e.o, e.d, e.b);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'hF;
        tick  = 1'b0;
        data0 = 16'h1234;
        data1 = 16'hABCD;
        data2 = 16'h5A5A;
        data3 = 16'h0F0F;

        row(0, 4'hF, 0, 4'b0000, 0, 16'h0000, 4'hF, "reset1");
        row(0, 4'hF, 1, 4'b0000, 0, 16'h0000, 4'hF, "reset2");
        row(1, 4'b0100, 0, 4'b0100, 2, 16'h0000, 4'hF, "req_to_grant");
        row(1, 4'b0100, 0, 4'b0100, 2, 16'h5A5A, 4'h0, "dout_follow");
        row(1, 4'b0100, 1, 4'b0100, 2, 16'h5A5A, 4'h0, "hold_tick");
        row(1, 4'b1100, 0, 4'b0100, 2, 16'h5A5A, 4'h0, "pending_wait");
        row(1, 4'b1000, 0, 4'b1000, 3, 16'h5A5A, 4'h0, "early_release");
        row(1, 4'b1000, 0, 4'b1000, 3, 16'h0F0F, 4'h0, "new_owner_data");

`ifdef DISP_ARB_PRIO0_EN
        row(1, 4'b1001, 0, 4'b0001, 0, 16'h0F0F, 4'h0, "prio0_preempt");
        for (int i = 0; i < 4; i++)
            row(1, 4'b1001, 1, 4'b0001, 0, 16'h1234, 4'h0, "prio0_owner_dwell");
        row(1, 4'b1001, 0, 4'b1000, 3, 16'h1234, 4'h0, "prio0_expire");
        row(1, 4'b1001, 0, 4'b0001, 0, 16'h0F0F, 4'h0, "prio0_repreempt");
`else
        row(1, 4'b1001, 0, 4'b1000, 3, 16'h0F0F, 4'h0, "no_preempt");
        for (int i = 0; i < 4; i++)
            row(1, 4'b1001, 1, 4'b1000, 3, 16'h0F0F, 4'h0, "no_preempt_dwell");
        row(1, 4'b1001, 0, 4'b0001, 0, 16'h0F0F, 4'h0, "dwell_expire0");
        row(1, 4'b1001, 0, 4'b0001, 0, 16'h1234, 4'h0, "owner0_data");
`endif

        row(0, 4'b1001, 1, 4'b0000, 0, 16'h0000, 4'hF, "reset_mid_hold");
        row(1, 4'b0000, 1, 4'b0000, 0, 16'h0000, 4'hF, "idle_no_req");

        row(1, RR_REQ, 0, GA, RR_A, 16'h0000, 4'hF, "rr_first");
        for (int i = 0; i < 7; i++)
            row(1, RR_REQ, (i % 2 == 0) ? 1'b1 : 1'b0, GA, RR_A, RR_DA, 4'h0, "rr_dwell_a");
        row(1, RR_REQ, 1, GB, RR_B, RR_DA, 4'h0, "rr_expire_a");
        for (int i = 0; i < 4; i++)
            row(1, RR_REQ, 1, GB, RR_B, RR_DB, 4'h0, "rr_tick_dropped");
        row(1, RR_REQ, 0, GA, RR_A, RR_DB, 4'h0, "rr_expire_b");
        row(1, RR_REQ, 0, GA, RR_A, RR_DA, 4'h0, "rr_back_a");

        row(1, 4'b0000, 0, 4'b0000, 0, RR_DA, 4'h0, "release_to_idle");
        row(1, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'hF, "idle_blank");
        row(1, 4'b0010, 0, 4'b0010, 1, 16'h0000, 4'hF, "solo_grant");
        for (int i = 0; i < 20; i++)
            row(1, 4'b0010, 1, 4'b0010, 1, 16'hABCD, 4'h0, "solo_hold");
        data1 = 16'h4321;
        row(1, 4'b0010, 0, 4'b0010, 1, 16'h4321, 4'h0, "live_data");
        row(1, 4'b1010, 0, 4'b1000, 3, 16'h4321, 4'h0, "saturated_switch");
        row(1, 4'b1000, 1, 4'b1000, 3, 16'h0F0F, 4'h0, "owner3_tick");
        row(1, 4'b0000, 1, 4'b0000, 0, 16'h0F0F, 4'h0, "tick_and_release");
        row(1, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'hF, "idle_after_release");
        row(1, 4'b1000, 0, 4'b1000, 3, 16'h0000, 4'hF, "regrant_3");

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            fails = fails + sb_q.size();
            $display("FAIL drain: %0d checks still pending, want 0", sb_q.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
